fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Drain side for the 8-bit FIFO. Pops bytes through the FIFO's read port (rd strobe, fall-through dout, empty flag) and serialises each byte as an 8N1 UART frame on txd. Sits between the FIFO's read port and the board TX pin. Runs in the FIFO's clock domain.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  when high, new frames may start; a frame in progress always completes
fifo_dout  in  8  FIFO read data; fall-through, valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag, active-high
fifo_rd  out  1  FIFO read strobe, active-high, one-cycle pulse per popped byte
txd  out  1  UART serial output, idle high
busy  out  1  high while a frame is being transmitted

Behaviour:
- Clock clk; reset is synchronous, active-high. All outputs are registered.
- Reset values: txd=1, fifo_rd=0, busy=0, state=IDLE, baud count=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, STOP.
- IDLE: at a clk edge where enable=1 and fifo_empty=0:
  - latch fifo_dout into the shift register;
  - set fifo_rd=1 for exactly the next cycle;
  - go to START with txd=0 and busy=1 from the next cycle.
  Otherwise stay in IDLE with txd=1 and fifo_rd=0.
- Pop timing: the FIFO advances its pointer at the edge that ends the fifo_rd cycle. Each pop produces exactly one fifo_rd pulse. fifo_rd is never asserted in a cycle that follows an edge where fifo_empty=1 was sampled.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - txd = shift register bit[index], LSB first;
  - each bit is held CLKS_PER_BIT cycles;
  - after index 7 completes, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
  - if enable=1 and fifo_empty=0: load the next byte, pulse fifo_rd, and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE and drop busy.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: txd falls one cycle after the sampling edge.
- Baud counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1, wraps to 0;
  - cleared on every frame start, so every bit has exact width, with no drift or carry-over between frames.
- Bit index is 3 bits and saturates at 7. No arithmetic wider than the counter.
- enable deasserted mid-frame: the current frame completes; no further pop occurs.
- fifo_empty going high mid-frame: no effect on the current frame (data is already latched).
- Reset mid-frame: in the next cycle txd=1, busy=0, fifo_rd=0, state=IDLE. The partial byte is lost and is not re-read.
- fifo_dout is ignored except at a load edge.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - IDLE_LEVEL=1'b1.
- Sub-module uart_baud_tick:
  - parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick;
  - tick is high on the last cycle of each bit period.
- The FSM, shift register and bit index stay in fifo_uart_tx.

Test Plan:
1. Reset with fifo_empty=1 held for 20 cycles -> txd=1, fifo_rd=0 and busy=0 on every cycle.
2. CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1 ->
   - exactly one fifo_rd pulse;
   - txd reads 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles;
   - busy high for exactly 40 cycles.
3. CLKS_PER_BIT=4, FIFO holds 0x00 then 0xFF ->
   - two fifo_rd pulses exactly 40 cycles apart;
   - second start bit immediately follows the first stop bit;
   - FIFO empty afterwards and txd=1.
4. enable=0 with 3 bytes queued for 100 cycles -> no fifo_rd, txd=1. Drop enable mid-frame -> that frame completes, then no further pop.
5. reset asserted at cycle 15 of a frame (CLKS_PER_BIT=4) -> next cycle txd=1, busy=0, fifo_rd=0. After release with the FIFO non-empty -> the next byte is sent correctly.
6. Random bytes through the FIFO at random enable duty, CLKS_PER_BIT=2 -> a txd decoder recovers the same sequence with no loss or duplication, and fifo_rd is never high while fifo_empty=1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The frame is 8N1: one start bit, DATA_BITS data bits sent LSB first, one stop bit.
package fifo_uart_pkg;

   // Payload width of one UART frame.
   localparam int DATA_BITS = 8;

   // Line levels: the line idles (and stops) high, and the start bit pulls it low.
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Bit index width and the index of the last data bit (MSB).
   localparam int                   BIT_IDX_W    = $clog2(DATA_BITS);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

   // Transmitter states. START/DATA/STOP each last a whole number of bit periods.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps. tick is high on the last cycle of each bit
// period. clear restarts the count at 0, so the period that starts after a clear
// has its full length. This keeps every bit exact and stops any carry-over
// between frames.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Free-running, wrapping bit-period counter. It restarts on clear.
   // NOTE: sequential state is assigned with <= only. Every flop then samples the
   // pre-edge values, whatever order the statements come in.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain side for the 8-bit fall-through FIFO.
// The block pops one byte at a time through the FIFO read port and sends it as an
// 8N1 frame on txd. If the FIFO still has data when the stop bit ends, the next
// frame follows back-to-back with no idle gap. All outputs come straight from
// flops.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DATA_BITS-1:0] fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_rd,
   output logic                 txd,
   output logic                 busy
);

   // Registered state
   state_t               r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BIT_IDX_W-1:0] r_bit_idx;
   logic                 r_txd;
   logic                 r_busy;
   logic                 r_fifo_rd;

   // Next-state values
   state_t               w_state_next;
   logic [DATA_BITS-1:0] w_shift_next;
   logic [BIT_IDX_W-1:0] w_bit_idx_next;
   logic                 w_txd_next;
   logic                 w_busy_next;
   logic                 w_fifo_rd_next;

   // Control
   logic                 w_tick;
   logic                 w_can_load;
   logic                 w_load;

   // A new byte may be taken only when frames are enabled and the FIFO shows data.
   // fifo_dout is looked at only on the edge where w_load is high.
   assign w_can_load = enable && !fifo_empty;

   // The load edge restarts the bit timer, so the start bit gets its full width.
   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .clear(w_load),
      .tick (w_tick)
   );

   // Next-state logic: walk START -> DATA x8 -> STOP, one bit per tick, and
   // chain straight into the next frame when a byte is waiting at the end of STOP.
   always_comb begin
      // NOTE: every signal gets a default before the case. No path can then leave
      // one unassigned, so no latch is inferred.
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      w_txd_next     = r_txd;
      w_busy_next    = r_busy;
      w_fifo_rd_next = 1'b0;
      w_load         = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_txd_next  = IDLE_LEVEL;
            w_busy_next = 1'b0;
            if (w_can_load) begin
               w_load = 1'b1;
            end
         end

         START: begin
            if (w_tick) begin
               w_state_next   = DATA;
               w_bit_idx_next = '0;
               w_txd_next     = r_shift[0];
            end
         end

         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == LAST_BIT_IDX) begin
                  // The index stays at 7 here; START sets it back to 0 for the next frame.
                  w_state_next = STOP;
                  w_txd_next   = IDLE_LEVEL;
               end else begin
                  w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
                  w_txd_next     = r_shift[w_bit_idx_next];
               end
            end
         end

         STOP: begin
            if (w_tick) begin
               if (w_can_load) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = IDLE;
                  w_busy_next  = 1'b0;
                  w_txd_next   = IDLE_LEVEL;
               end
            end
         end

         default: begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_txd_next   = IDLE_LEVEL;
         end
      endcase

      // Loading is the same from IDLE and from the last STOP cycle: take the byte,
      // pulse the read strobe for one cycle, and drive the start bit next cycle.
      // The FIFO advances on the edge that ends the strobe cycle. fifo_dout has
      // already been captured by then.
      if (w_load) begin
         w_shift_next   = fifo_dout;
         w_fifo_rd_next = 1'b1;
         w_state_next   = START;
         w_txd_next     = START_LEVEL;
         w_busy_next    = 1'b1;
      end
   end

   // State and output registers, with a synchronous reset.
   // A reset in the middle of a frame drops the partial byte and does not re-read it.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the shift register is reset with the rest of the state. It is a
         // single flop word, not a memory array, so the reset costs nothing and
         // keeps the flops clear of X in simulation.
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_txd     <= IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_fifo_rd <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_txd     <= w_txd_next;
         r_busy    <= w_busy_next;
         r_fifo_rd <= w_fifo_rd_next;
      end
   end

   assign fifo_rd = r_fifo_rd;
   assign txd     = r_txd;
   assign busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx.
// Two instances are used: one with 4 clocks per bit for the directed frame checks,
// and one with 2 clocks per bit for the random stream. Each instance is fed from
// its own queue, which behaves as a fall-through FIFO.
module tb_fifo_uart_tx;

   localparam int CPB4 = 4;
   localparam int CPB2 = 2;

   logic       clk;
   logic       reset;

   logic       en4, empty4, rd4, txd4, busy4;
   logic [7:0] dout4;
   logic       en2, empty2, rd2, txd2, busy2;
   logic [7:0] dout2;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB4)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .enable    (en4),
      .fifo_dout (dout4),
      .fifo_empty(empty4),
      .fifo_rd   (rd4),
      .txd       (txd4),
      .busy      (busy4)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB2)) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .enable    (en2),
      .fifo_dout (dout2),
      .fifo_empty(empty2),
      .fifo_rd   (rd2),
      .txd       (txd2),
      .busy      (busy2)
   );

   // FIFO contents and the bytes popped from the random-stream FIFO, in order
   logic [7:0] q4[$];
   logic [7:0] q2[$];
   logic [7:0] sent2[$];

   int         n_checks;
   int         n_fail;
   int         n_pushed;
   int         rx_count;

   // Line decoder state for the random-stream instance
   logic       dec_active;
   int         dec_cnt;
   logic [7:0] dec_byte;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // Expected line level for frame slot 0..9: start bit, data bits LSB first, stop bit
   function automatic logic frame_level(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      else if (slot <= 8) return b[slot-1];
      else return 1'b1;
   endfunction

   // Fall-through FIFO outputs follow the queue head
   task automatic fifo_update();
      empty4 = (q4.size() == 0);
      dout4  = empty4 ? 8'h00 : q4[0];
      empty2 = (q2.size() == 0);
      dout2  = empty2 ? 8'h00 : q2[0];
   endtask

   // Line decoder: samples the middle of each bit period once a start edge is seen
   task automatic decode2();
      int slot;
      if (!dec_active) begin
         if (txd2 == 1'b0) begin
            dec_active = 1'b1;
            dec_cnt    = 0;
         end
      end else begin
         dec_cnt++;
      end
      if (dec_active && (dec_cnt % CPB2) == CPB2 / 2) begin
         slot = dec_cnt / CPB2;
         if (slot == 0) begin
            check("rx_start", 32'(txd2), 32'd0);
         end else if (slot <= 8) begin
            dec_byte[slot-1] = txd2;
         end else begin
            check("rx_stop", 32'(txd2), 32'd1);
            check("rx_pending", 32'(sent2.size() > 0), 32'd1);
            if (sent2.size() > 0) check("rx_byte", 32'(dec_byte), 32'(sent2.pop_front()));
            rx_count++;
            dec_active = 1'b0;
         end
      end
   endtask

   // Advance one clock. The FIFOs pop on the edge that ends a read-strobe cycle.
   // Outputs are sampled 1 time unit after the edge.
   task automatic step();
      logic rd4_s, rd2_s;
      rd4_s = rd4;
      rd2_s = rd2;
      @(posedge clk);
      #1;
      if (rd4_s && q4.size() > 0) q4.delete(0);
      if (rd2_s && q2.size() > 0) sent2.push_back(q2.pop_front());
      fifo_update();
      check("rd4_while_empty", 32'(rd4 & empty4), 32'd0);
      check("rd2_while_empty", 32'(rd2 & empty2), 32'd0);
      decode2();
   endtask

   // Check frame cycles [first, last) of byte b on the 4-clock instance. Cycle 0 is
   // the cycle right after the load edge; the first step() of a new frame is that edge.
   task automatic check_frame4(input logic [7:0] b, input int first, input int last);
      for (int i = first; i < last; i++) begin
         step();
         check("frame_txd", 32'(txd4), 32'(frame_level(b, i / CPB4)));
         check("frame_busy", 32'(busy4), 32'd1);
         check("frame_rd", 32'(rd4), 32'(i == 0));
      end
   endtask

   task automatic check_idle4(input string tag);
      check({tag, "_txd"}, 32'(txd4), 32'd1);
      check({tag, "_busy"}, 32'(busy4), 32'd0);
      check({tag, "_rd"}, 32'(rd4), 32'd0);
   endtask

   initial begin
      logic [7:0] b0, b1, b2;
      int         guard;

      n_checks   = 0;
      n_fail     = 0;
      n_pushed   = 0;
      rx_count   = 0;
      dec_active = 1'b0;
      dec_cnt    = 0;
      dec_byte   = 8'h00;
      reset      = 1'b1;
      en4        = 1'b0;
      en2        = 1'b0;
      fifo_update();

      // 1: held in reset with an empty FIFO
      repeat (20) begin
         step();
         check_idle4("reset");
      end
      reset = 1'b0;

      // 2: single frame of 0xA5
      en4 = 1'b1;
      q4.push_back(8'hA5);
      fifo_update();
      check_frame4(8'hA5, 0, 40);
      step();
      check_idle4("after_a5");
      check("a5_fifo_left", 32'(q4.size()), 32'd0);

      // 3: back-to-back 0x00 then 0xFF
      q4.push_back(8'h00);
      q4.push_back(8'hFF);
      fifo_update();
      check_frame4(8'h00, 0, 40);
      check_frame4(8'hFF, 0, 40);
      step();
      check_idle4("after_b2b");
      check("b2b_fifo_left", 32'(q4.size()), 32'd0);

      // 4: enable low with data queued, then enable dropped mid-frame
      en4 = 1'b0;
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      b2  = 8'($urandom);
      q4.push_back(b0);
      q4.push_back(b1);
      q4.push_back(b2);
      fifo_update();
      repeat (100) begin
         step();
         check("disabled_rd", 32'(rd4), 32'd0);
         check("disabled_txd", 32'(txd4), 32'd1);
      end
      en4 = 1'b1;
      check_frame4(b0, 0, 10);
      en4 = 1'b0;
      check_frame4(b0, 10, 40);
      repeat (60) begin
         step();
         check_idle4("drop_en");
      end
      check("drop_en_fifo_left", 32'(q4.size()), 32'd2);

      // 5: reset at cycle 15 of a frame, then the next byte goes out intact
      en4 = 1'b1;
      check_frame4(b1, 0, 15);
      reset = 1'b1;
      step();
      check_idle4("mid_reset");
      reset = 1'b0;
      check_frame4(b2, 0, 40);
      step();
      check_idle4("after_reset");
      check("reset_fifo_left", 32'(q4.size()), 32'd0);
      en4 = 1'b0;

      // 6: random bytes at random enable duty, decoded from the 2-clock line
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0 && q2.size() < 6) begin
            q2.push_back(8'($urandom));
            n_pushed++;
         end
         en2 = ($urandom_range(0, 9) < 7);
         fifo_update();
         step();
      end
      en2   = 1'b1;
      guard = 0;
      while ((q2.size() > 0 || busy2 || dec_active) && guard < 2000) begin
         step();
         guard++;
      end
      check("drain_in_time", 32'(guard < 2000), 32'd1);
      check("rx_count", 32'(rx_count), 32'(n_pushed));
      check("sent_undecoded", 32'(sent2.size()), 32'd0);
      check("rand_txd_idle", 32'(txd2), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
